// File: rtl/mul_result_stage.sv
// Multiplier result stage: sign-corrects the raw 64-bit product, selects a word, and buffers it in a FIFO.
// Define MUL_RES_OVF_EN to add the per-entry signed-overflow flag and the out_ovf output.
module mul_result_stage #(
   parameter int DEPTH = 2,
   parameter int TAG_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [63:0]      in_product,
   input  logic             in_negate,
   input  logic             in_sel_hi,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_result,
`ifdef MUL_RES_OVF_EN
   output logic             out_ovf,
`endif
   output logic [TAG_W-1:0] out_tag
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic [CNT_W-1:0] count;

   logic [31:0]      mem_result [DEPTH];
   logic [TAG_W-1:0] mem_tag    [DEPTH];

   logic [63:0] full;
   logic [31:0] word;
   logic        push;
   logic        pop;
   logic        not_empty;

   always_comb begin
      full = in_negate ? (~in_product + 64'd1) : in_product;
      word = in_sel_hi ? full[63:32] : full[31:0];
   end

   // No bypass: a full FIFO refuses input even when the head pops this cycle.
   assign not_empty = (count != '0);
   assign in_ready  = (count < CNT_W'(DEPTH));
   assign out_valid = not_empty;
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)
            rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage is deliberately left out of reset; the count alone decides what is live.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_result[wr_ptr] <= word;
         mem_tag[wr_ptr]    <= in_tag;
      end
   end

   assign out_result = not_empty ? mem_result[rd_ptr] : 32'd0;
   assign out_tag    = not_empty ? mem_tag[rd_ptr] : '0;

`ifdef MUL_RES_OVF_EN
   logic mem_ovf [DEPTH];
   logic ovf_flag;

   // Low-word result overflowed if the high word is not the sign extension of bit 31.
   assign ovf_flag = !in_sel_hi && (full[63:32] != {32{full[31]}});

   always_ff @(posedge clk) begin
      if (push)
         mem_ovf[wr_ptr] <= ovf_flag;
   end

   assign out_ovf = not_empty && mem_ovf[rd_ptr];
`endif

endmodule
